// File: rtl/restoring_divider.sv
// restoring_divider: multi-cycle restoring divider, one quotient bit per ITER cycle.
// Define DIV_SIGNED_EN for two's-complement operands (adds the FIX sign-correction state).
`default_nettype none

module restoring_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] INIT = 3'd1;
  localparam logic [2:0] ITER = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
`ifdef DIV_SIGNED_EN
  localparam logic [2:0] FIX  = 3'd4;
`endif

  logic [2:0]       state, state_next;
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [CW-1:0]    count;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic             last_iter;
`ifdef DIV_SIGNED_EN
  logic             neg_q;
  logic             neg_r;
`endif

  // Trial subtraction on the shifted {A,Q}; the extra top bit of diff is the borrow.
  always_comb begin
    diff      = {a, q[WIDTH-1]} - {2'b00, m};
    if (diff[WIDTH+1]) begin
      a_next = {a[WIDTH-1:0], q[WIDTH-1]};
      q_next = {q[WIDTH-2:0], 1'b0};
    end else begin
      a_next = diff[WIDTH:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end
    last_iter = (count == CW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = INIT;
      INIT: state_next = (m == '0) ? DONE : ITER;
`ifdef DIV_SIGNED_EN
      ITER: if (last_iter) state_next = FIX;
      FIX:  state_next = DONE;
`else
      ITER: if (last_iter) state_next = DONE;
`endif
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a           <= '0;
      q           <= '0;
      m           <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          q <= dividend;
          m <= divisor;
`ifdef DIV_SIGNED_EN
          neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_r <= dividend[WIDTH-1];
`endif
        end
        INIT: begin
          div_by_zero <= 1'b0;
          if (m == '0) begin
            div_by_zero <= 1'b1;
            quotient    <= '1;
            remainder   <= q;
          end else begin
            a     <= '0;
            count <= CW'(WIDTH);
`ifdef DIV_SIGNED_EN
            q <= q[WIDTH-1] ? -q : q;
            m <= m[WIDTH-1] ? -m : m;
`endif
          end
        end
        ITER: begin
          a     <= a_next;
          q     <= q_next;
          count <= count - CW'(1);
`ifndef DIV_SIGNED_EN
          if (last_iter) begin
            quotient  <= q_next;
            remainder <= a_next[WIDTH-1:0];
          end
`endif
        end
`ifdef DIV_SIGNED_EN
        FIX: begin
          quotient  <= neg_q ? -q : q;
          remainder <= neg_r ? -a[WIDTH-1:0] : a[WIDTH-1:0];
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
